// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the team FIFO's single write port between N
// valid/ready producers, with bounded bursts and immediate re-arbitration.
module fifo_wr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    input  logic            fifo_full,
    output logic            fifo_wr_en,
    output logic [DW-1:0]   fifo_data,
    output logic [N-1:0]    grant,
    output logic            busy
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  grant_n;
    logic [PW-1:0] gidx, gidx_n;
    logic [PW-1:0] rr_ptr, rr_n;
    logic [BW-1:0] beat_cnt, beat_n;
    logic [DW-1:0] words [N];

    // First set bit of mask scanning upward from start, wrapping at N-1.
    function automatic logic [N-1:0] pick_oh(input logic [PW-1:0] start,
                                             input logic [N-1:0]  mask);
        logic [N-1:0]  oh;
        logic          done;
        logic [PW-1:0] idx;
        int            j;
        oh   = '0;
        done = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            j = int'(start) + k;
            if (j >= int'(N)) j = j - int'(N);
            idx = PW'(j);
            if (!done && mask[idx]) begin
                oh[idx] = 1'b1;
                done    = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [PW-1:0] enc(input logic [N-1:0] oh);
        logic [PW-1:0] idx;
        logic [PW-1:0] kk;
        idx = '0;
        for (int k = 0; k < int'(N); k++) begin
            kk = PW'(k);
            if (oh[kk]) idx = kk;
        end
        return idx;
    endfunction

    for (genvar gi = 0; gi < int'(N); gi++) begin : g_words
        assign words[gi] = req_data[gi*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            gidx     <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            gidx     <= gidx_n;
            rr_ptr   <= rr_n;
            beat_cnt <= beat_n;
            busy     <= (state_n == GRANT);
        end
    end

    // Next-state: burst accounting, release and zero-bubble re-pick.
    always_comb begin
        logic          xfer;
        logic          rel_a;
        logic          rel_b;
        logic [PW-1:0] nxt;
        logic [N-1:0]  mask;
        logic [N-1:0]  pick;
        state_n = state;
        grant_n = grant;
        gidx_n  = gidx;
        rr_n    = rr_ptr;
        beat_n  = beat_cnt;
        xfer    = req_valid[gidx] & ~fifo_full;
        rel_a   = xfer && (beat_cnt == BW'(BURST - 1));
        rel_b   = ~req_valid[gidx];
        nxt     = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
        mask    = req_valid;
        pick    = '0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    pick    = pick_oh(rr_ptr, req_valid);
                    grant_n = pick;
                    gidx_n  = enc(pick);
                    beat_n  = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (xfer) beat_n = beat_cnt + BW'(1);
                if (rel_a || rel_b) begin
                    rr_n = nxt;
                    if (rel_b) mask[gidx] = 1'b0;
                    pick = pick_oh(nxt, mask);
                    beat_n = '0;
                    if (|pick) begin
                        grant_n = pick;
                        gidx_n  = enc(pick);
                    end else begin
                        grant_n = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake and write port; suppressed while reset is asserted so no word is taken.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_data  = '0;
        if (!rst) begin
            req_ready  = grant & {N{~fifo_full}};
            fifo_wr_en = (|(grant & req_valid)) & ~fifo_full;
        end
        if (|grant) fifo_data = words[gidx];
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N=4, DW=8, BURST=2) with a small FIFO
// model for the end-to-end scoreboard.
module tb_fifo_wr_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned BURST = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data;
    logic [N-1:0]    grant;
    logic            busy;

    int n_pass   = 0;
    int n_checks = 0;

    fifo_wr_arbiter #(.N(N), .DW(DW), .BURST(BURST)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .grant      (grant),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        next_cycle();
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_word(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    initial begin
        int          order [10];
        logic [7:0]  q [$];
        logic [7:0]  w;
        int          ptr [2];
        int          exp_n [2];
        int          popped;
        int          s;

        order     = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        rst       = 1'b1;
        req_valid = 4'b1111;
        fifo_full = 1'b0;
        req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // Reset held with every requester valid.
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        next_cycle();
        @(negedge clk);
        check("rst2_ready", 32'(req_ready), 32'h0);
        check("rst2_wr_en", 32'(fifo_wr_en), 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_wr_en", 32'(fifo_wr_en), 32'h0);

        // Round robin, BURST=2, all valid: 0,0,1,1,2,2,3,3,0,0.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(grant), 32'(1 << order[k]));
            check("rr_wr_en", 32'(fifo_wr_en), 32'h1);
            check("rr_data", 32'(fifo_data), 32'h0A0 + 32'h11 * 32'(order[k]));
        end
        check("rr_busy", 32'(busy), 32'h1);

        // Early release: requester 1 sends one word then drops, 3 takes over.
        reset_dut();
        req_valid = 4'b1010;
        next_cycle();
        @(negedge clk);
        check("er_grant1", 32'(grant), 32'h2);
        check("er_data1", 32'(fifo_data), 32'hB1);
        check("er_ready1", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = 4'b1000;
        @(negedge clk);
        check("er_nowrite", 32'(fifo_wr_en), 32'h0);
        next_cycle();
        @(negedge clk);
        check("er_grant3", 32'(grant), 32'h8);
        check("er_data3", 32'(fifo_data), 32'hD3);
        check("er_rr_ptr", 32'(dut.rr_ptr), 32'h2);

        // Full stall mid-burst of requester 2 with 0xA5 pending.
        reset_dut();
        req_valid = 4'b0100;
        set_word(2, 8'h5A);
        next_cycle();
        @(negedge clk);
        check("fs_grant", 32'(grant), 32'h4);
        check("fs_data0", 32'(fifo_data), 32'h5A);
        check("fs_wr0", 32'(fifo_wr_en), 32'h1);
        next_cycle();
        set_word(2, 8'hA5);
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("fs_ready", 32'(req_ready), 32'h0);
            check("fs_wr_en", 32'(fifo_wr_en), 32'h0);
            check("fs_hold", 32'(grant), 32'h4);
            check("fs_beat", 32'(dut.beat_cnt), 32'h1);
            next_cycle();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        check("fs_resume_wr", 32'(fifo_wr_en), 32'h1);
        check("fs_resume_data", 32'(fifo_data), 32'hA5);
        check("fs_resume_ready", 32'(req_ready), 32'h4);

        // Reset mid-burst with grant=0010, beat_cnt=1 and rr_ptr=1.
        reset_dut();
        set_word(0, 8'hA0);
        set_word(1, 8'hB1);
        req_valid = 4'b0011;
        for (int k = 0; k < 4; k++) next_cycle();
        @(negedge clk);
        check("rm_grant", 32'(grant), 32'h2);
        check("rm_beat", 32'(dut.beat_cnt), 32'h1);
        rst = 1'b1;
        #1;
        check("rm_no_write", 32'(fifo_wr_en), 32'h0);
        check("rm_no_ready", 32'(req_ready), 32'h0);
        next_cycle();
        rst       = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        check("rm_grant_zero", 32'(grant), 32'h0);
        check("rm_busy_zero", 32'(busy), 32'h0);
        next_cycle();
        @(negedge clk);
        check("rm_restart", 32'(grant), 32'h1);

        // Scoreboard: 4-deep FIFO draining one word every 3 cycles.
        reset_dut();
        ptr    = '{0, 0};
        exp_n  = '{0, 0};
        popped = 0;
        for (int c = 0; c < 400 && popped < 16; c++) begin
            fifo_full = (q.size() >= 4);
            req_valid = '0;
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = (ptr[i] < 8);
                set_word(i, 8'(16 * i + ptr[i]));
            end
            @(negedge clk);
            if (fifo_wr_en) q.push_back(fifo_data);
            for (int i = 0; i < 2; i++)
                if (req_valid[i] && req_ready[i]) ptr[i]++;
            if ((c % 3) == 2 && q.size() > 0) begin
                w = q.pop_front();
                s = int'(w[4]);
                check("sb_order", 32'(w), 32'(16 * s + exp_n[s]));
                exp_n[s]++;
                popped++;
            end
            next_cycle();
        end
        check("sb_count", 32'(popped), 32'd16);
        check("sb_src0_sent", 32'(ptr[0]), 32'd8);
        check("sb_src1_sent", 32'(ptr[1]), 32'd8);
        check("sb_fifo_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
